// File: rtl/rx_udp_port_dispatch.sv
// rx_udp_port_dispatch
//   Receive-side UDP dispatcher. Parses the 8-byte UDP header of each
//   incoming segment, looks the destination port up in an NCH-entry
//   binding table and forwards the payload to the lowest-indexed matching
//   enabled channel, or drops the segment and counts it.
//
// Ports
//   RX_CLK        receive clock (posedge)
//   rst           synchronous active-high reset
//   cfg_we        binding-table write strobe
//   cfg_idx       binding-table entry index
//   cfg_en        entry enable written with cfg_we
//   cfg_port      UDP port bound to the entry
//   rx_data_v     segment byte valid (high for a whole segment)
//   rx_data       segment byte, header first, big-endian fields
//   ch_data_v     one-hot payload valid per channel
//   ch_data       payload byte shared by all channels (holds when idle)
//   ch_sof        first payload byte (with ch_data_v)
//   ch_eof        last payload byte (with ch_data_v)
//   ch_abort      one-cycle pulse: forwarded segment truncated
//   rx_src_port   source port of the current/last segment
//   drop_cnt      saturating count of dropped segments
//   busy          high from the first header byte until segment end
module rx_udp_port_dispatch #(
  parameter int OCT = 8,
  parameter int NCH = 4
) (
  input  logic                   RX_CLK,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_idx,
  input  logic                   cfg_en,
  input  logic [2*OCT-1:0]       cfg_port,
  input  logic                   rx_data_v,
  input  logic [OCT-1:0]         rx_data,
  output logic [NCH-1:0]         ch_data_v,
  output logic [OCT-1:0]         ch_data,
  output logic                   ch_sof,
  output logic                   ch_eof,
  output logic [NCH-1:0]         ch_abort,
  output logic [2*OCT-1:0]       rx_src_port,
  output logic [15:0]            drop_cnt,
  output logic                   busy
);

  localparam int                 IW      = $clog2(NCH);
  localparam logic [2*OCT-1:0]   HDR_LEN = (2*OCT)'(8);
  localparam logic [2*OCT-1:0]   ONE_W   = (2*OCT)'(1);
  localparam logic [NCH-1:0]     ONE_HOT = NCH'(1);

  typedef enum logic [1:0] {HDR, FWD, DROP, DONE} state_t;

  state_t            state, next_state;
  logic [2:0]        cnt;
  logic [OCT-1:0]    hi_byte;
  logic [2*OCT-1:0]  len;
  logic [2*OCT-1:0]  remaining;
  logic              tbl_en   [NCH];
  logic [2*OCT-1:0]  tbl_port [NCH];
  logic [IW-1:0]     sel, lk_sel;
  logic              hit, lk_hit;
  logic              first;
  logic              hdr_acc, last_hdr, fwd_acc, is_drop;

  // Lookup reads the registered table, so a write in the same cycle is
  // only seen by later lookups.
  always_comb begin
    hdr_acc  = rx_data_v && (state == HDR);
    last_hdr = hdr_acc && (cnt == 3'd7);
    fwd_acc  = rx_data_v && (state == FWD);
    is_drop  = (len < HDR_LEN) || !hit;

    lk_hit = 1'b0;
    lk_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!lk_hit && tbl_en[i] && (tbl_port[i] == {hi_byte, rx_data})) begin
        lk_hit = 1'b1;
        lk_sel = IW'(i);
      end
    end

    next_state = state;
    if (!rx_data_v) begin
      next_state = HDR;
    end else begin
      case (state)
        HDR: begin
          if (last_hdr) begin
            if (is_drop)             next_state = DROP;
            else if (len == HDR_LEN) next_state = DONE;
            else                     next_state = FWD;
          end
        end
        FWD: begin
          if (remaining == ONE_W) next_state = DONE;
        end
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) state <= HDR;
    else     state <= next_state;
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      ch_data_v   <= '0;
      ch_data     <= '0;
      ch_sof      <= 1'b0;
      ch_eof      <= 1'b0;
      ch_abort    <= '0;
      rx_src_port <= '0;
      drop_cnt    <= '0;
      busy        <= 1'b0;
      cnt         <= '0;
      hi_byte     <= '0;
      len         <= '0;
      remaining   <= '0;
      sel         <= '0;
      hit         <= 1'b0;
      first       <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        tbl_en[i]   <= 1'b0;
        tbl_port[i] <= '0;
      end
    end else begin
      ch_data_v <= '0;
      ch_sof    <= 1'b0;
      ch_eof    <= 1'b0;
      ch_abort  <= '0;
      busy      <= rx_data_v;

      if (cfg_we) begin
        tbl_en[cfg_idx]   <= cfg_en;
        tbl_port[cfg_idx] <= cfg_port;
      end

      // FWD always has payload outstanding, so a gap there is a truncation.
      if (!rx_data_v) begin
        cnt <= '0;
        if (state == FWD) ch_abort <= ONE_HOT << sel;
      end

      if (hdr_acc) begin
        cnt <= cnt + 3'd1;
        case (cnt)
          3'd0, 3'd2, 3'd4: hi_byte <= rx_data;
          3'd1: rx_src_port <= {hi_byte, rx_data};
          3'd3: begin
            sel <= lk_sel;
            hit <= lk_hit;
          end
          3'd5: len <= {hi_byte, rx_data};
          3'd7: begin
            remaining <= len - HDR_LEN;
            first     <= 1'b1;
            if (is_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
          end
          default: ;
        endcase
      end

      if (fwd_acc) begin
        ch_data_v <= ONE_HOT << sel;
        ch_data   <= rx_data;
        ch_sof    <= first;
        ch_eof    <= (remaining == ONE_W);
        first     <= 1'b0;
        remaining <= remaining - ONE_W;
      end
    end
  end

endmodule

// File: tb/tb_rx_udp_port_dispatch.sv
// tb_rx_udp_port_dispatch
//   Self-checking bench for rx_udp_port_dispatch: directed segments from the
//   test plan followed by randomized segments, each checked against a
//   segment-level reference model (table lookup, drop/forward decision,
//   expected payload events with cycle stamps, abort pulses).
module tb_rx_udp_port_dispatch;

  localparam int OCT = 8;
  localparam int NCH = 4;

  logic             RX_CLK = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [1:0]       cfg_idx;
  logic             cfg_en;
  logic [15:0]      cfg_port;
  logic             rx_data_v;
  logic [7:0]       rx_data;
  logic [NCH-1:0]   ch_data_v;
  logic [7:0]       ch_data;
  logic             ch_sof;
  logic             ch_eof;
  logic [NCH-1:0]   ch_abort;
  logic [15:0]      rx_src_port;
  logic [15:0]      drop_cnt;
  logic             busy;

  rx_udp_port_dispatch #(.OCT(OCT), .NCH(NCH)) dut (
    .RX_CLK(RX_CLK), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_port(cfg_port),
    .rx_data_v(rx_data_v), .rx_data(rx_data),
    .ch_data_v(ch_data_v), .ch_data(ch_data), .ch_sof(ch_sof), .ch_eof(ch_eof),
    .ch_abort(ch_abort), .rx_src_port(rx_src_port), .drop_cnt(drop_cnt),
    .busy(busy)
  );

  always #5 RX_CLK = ~RX_CLK;

  int cyc = 0;
  always @(posedge RX_CLK) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] v;
    logic [7:0]     d;
    logic           sof;
    logic           eof;
  } ev_t;

  typedef struct {
    int             cyc;
    logic [NCH-1:0] ab;
  } ab_t;

  ev_t got_q[$], exp_q[$];
  ab_t got_ab[$], exp_ab[$];

  always @(negedge RX_CLK) begin
    if (|ch_data_v) got_q.push_back('{cyc, ch_data_v, ch_data, ch_sof, ch_eof});
    if (|ch_abort)  got_ab.push_back('{cyc, ch_abort});
  end

  int tests = 0;
  int fails = 0;

  // reference state
  logic        tbl_en_m   [NCH];
  logic [15:0] tbl_port_m [NCH];
  logic [15:0] drop_m;
  logic [15:0] src_m;

  // per-segment stimulus
  logic [7:0]  seg_q[$];
  int          dcyc[$];
  int          cfg_at = -1;
  logic [1:0]  cfg_w_idx;
  logic        cfg_w_en;
  logic [15:0] cfg_w_port;
  bit          rst_after = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      tbl_en_m[i]   = 1'b0;
      tbl_port_m[i] = 16'h0;
    end
    drop_m = 16'h0;
    src_m  = 16'h0;
  endtask

  task automatic cfg_write(input int idx, input logic en, input logic [15:0] port);
    @(posedge RX_CLK); #1;
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_en = en; cfg_port = port;
    @(posedge RX_CLK); #1;
    cfg_we = 1'b0;
    tbl_en_m[idx]   = en;
    tbl_port_m[idx] = port;
  endtask

  task automatic mk_seg(input logic [15:0] src, input logic [15:0] dst,
                        input logic [15:0] len, input int n);
    int total;
    total = (n > 8) ? n : 8;
    seg_q.delete();
    seg_q.push_back(src[15:8]); seg_q.push_back(src[7:0]);
    seg_q.push_back(dst[15:8]); seg_q.push_back(dst[7:0]);
    seg_q.push_back(len[15:8]); seg_q.push_back(len[7:0]);
    seg_q.push_back(8'($urandom)); seg_q.push_back(8'($urandom));
    while (seg_q.size() < total) seg_q.push_back(8'($urandom));
    while (seg_q.size() > n) void'(seg_q.pop_back());
  endtask

  task automatic run_seg(input string tag);
    logic        en_s   [NCH];
    logic [15:0] port_s [NCH];
    logic [15:0] dst, len;
    int n, sel, want, have, k_n;
    bit hit;
    ev_t e;
    ab_t a;

    en_s   = tbl_en_m;
    port_s = tbl_port_m;
    dcyc.delete();
    n = seg_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge RX_CLK); #1;
      rx_data_v = 1'b1;
      rx_data   = seg_q[i];
      cfg_we    = (i == cfg_at);
      cfg_idx   = cfg_w_idx;
      cfg_en    = cfg_w_en;
      cfg_port  = cfg_w_port;
      dcyc.push_back(cyc);
      if (i == 1) begin
        @(negedge RX_CLK);
        chk({tag, " busy_set"}, 32'(busy), 32'd1);
      end
    end
    @(posedge RX_CLK); #1;
    rx_data_v = 1'b0;
    cfg_we    = 1'b0;
    rst       = rst_after;
    @(posedge RX_CLK); #1;
    rst = 1'b0;
    repeat (3) @(posedge RX_CLK);
    #1;

    if (n >= 2) src_m = {seg_q[0], seg_q[1]};
    if (n >= 8) begin
      dst = {seg_q[2], seg_q[3]};
      len = {seg_q[4], seg_q[5]};
      hit = 0; sel = 0;
      for (int i = 0; i < NCH; i++)
        if (!hit && en_s[i] && port_s[i] == dst) begin hit = 1; sel = i; end
      if (len < 16'd8 || !hit) begin
        if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
      end else if (len > 16'd8) begin
        want = int'(len) - 8;
        have = n - 8;
        k_n  = (have < want) ? have : want;
        for (int k = 0; k < k_n; k++) begin
          e.cyc = dcyc[8+k] + 1;
          e.v   = NCH'(1) << sel;
          e.d   = seg_q[8+k];
          e.sof = (k == 0);
          e.eof = (k == want - 1);
          exp_q.push_back(e);
        end
        if (have < want && !rst_after) begin
          a.cyc = dcyc[n-1] + 2;
          a.ab  = NCH'(1) << sel;
          exp_ab.push_back(a);
        end
      end
    end
    if (cfg_at >= 0 && cfg_at < n) begin
      tbl_en_m[cfg_w_idx]   = cfg_w_en;
      tbl_port_m[cfg_w_idx] = cfg_w_port;
    end
    if (rst_after) model_reset();

    chk({tag, " n_out"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, " out_cyc"}, got_q[i].cyc, exp_q[i].cyc);
      chk({tag, " out_v_sof_eof_d"},
          {got_q[i].v, got_q[i].sof, got_q[i].eof, got_q[i].d},
          {exp_q[i].v, exp_q[i].sof, exp_q[i].eof, exp_q[i].d});
    end
    chk({tag, " n_abort"}, got_ab.size(), exp_ab.size());
    for (int i = 0; i < got_ab.size() && i < exp_ab.size(); i++) begin
      chk({tag, " abort_cyc"}, got_ab[i].cyc, exp_ab[i].cyc);
      chk({tag, " abort_ch"}, 32'(got_ab[i].ab), 32'(exp_ab[i].ab));
    end
    chk({tag, " busy_clr"}, 32'(busy), 32'd0);
    chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(drop_m));
    chk({tag, " src_port"}, 32'(rx_src_port), 32'(src_m));
    got_q.delete(); exp_q.delete(); got_ab.delete(); exp_ab.delete();
    cfg_at = -1;
    rst_after = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] dsts [5];
    logic [15:0] l_r;
    int full, n_r;

    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_port = '0;
    rx_data_v = 1'b0; rx_data = '0;
    cfg_w_idx = '0; cfg_w_en = 1'b0; cfg_w_port = '0;
    model_reset();
    repeat (3) @(posedge RX_CLK);
    #1 rst = 1'b0;
    @(negedge RX_CLK);
    chk("rst ch_data_v", 32'(ch_data_v), 32'd0);
    chk("rst ch_abort", 32'(ch_abort), 32'd0);
    chk("rst ch_sof", 32'(ch_sof), 32'd0);
    chk("rst ch_eof", 32'(ch_eof), 32'd0);
    chk("rst ch_data", 32'(ch_data), 32'd0);
    chk("rst src_port", 32'(rx_src_port), 32'd0);
    chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);

    // basic forward on channel 1
    cfg_write(1, 1'b1, 16'h1234);
    mk_seg(16'hABCD, 16'h1234, 16'h000C, 12);
    seg_q[8] = 8'hDE; seg_q[9] = 8'hAD; seg_q[10] = 8'hBE; seg_q[11] = 8'hEF;
    run_seg("fwd4");

    // two entries bound to the same port: lowest index wins, L=9
    cfg_write(0, 1'b1, 16'h0050);
    cfg_write(2, 1'b1, 16'h0050);
    mk_seg(16'h1111, 16'h0050, 16'h0009, 9);
    run_seg("prio_l9");

    // unmatched port -> drop
    mk_seg(16'h2222, 16'h0077, 16'h0010, 16);
    run_seg("nomatch");

    // short length -> drop; L=8 -> nothing, no drop
    mk_seg(16'h3333, 16'h1234, 16'h0006, 8);
    run_seg("len6");
    mk_seg(16'h4444, 16'h1234, 16'h0008, 8);
    run_seg("len8");

    // truncated forward after 5 payload bytes, then a clean segment
    mk_seg(16'h5555, 16'h1234, 16'h0014, 13);
    run_seg("trunc");
    mk_seg(16'h6666, 16'h1234, 16'h000C, 12);
    run_seg("after_trunc");

    // trailing padding
    mk_seg(16'h7777, 16'h0050, 16'h000A, 16);
    run_seg("pad");

    // disable matching entry mid-forward
    cfg_at = 9; cfg_w_idx = 2'd1; cfg_w_en = 1'b0; cfg_w_port = 16'h1234;
    mk_seg(16'h8888, 16'h1234, 16'h000C, 12);
    run_seg("cfg_midfwd");
    mk_seg(16'h9999, 16'h1234, 16'h000C, 12);
    run_seg("cfg_after");

    // write on the lookup cycle: old contents apply
    cfg_at = 3; cfg_w_idx = 2'd3; cfg_w_en = 1'b1; cfg_w_port = 16'h0099;
    mk_seg(16'hAAAA, 16'h0099, 16'h000A, 10);
    run_seg("cfg_lookup");
    mk_seg(16'hBBBB, 16'h0099, 16'h000A, 10);
    run_seg("cfg_lookup_next");

    // truncated header
    mk_seg(16'hCCCC, 16'h0050, 16'h0010, 5);
    run_seg("hdr_trunc");

    // drop counter saturation
    @(posedge RX_CLK); #1;
    force dut.drop_cnt = 16'hFFFE;
    @(posedge RX_CLK); #1;
    release dut.drop_cnt;
    drop_m = 16'hFFFE;
    mk_seg(16'hDDDD, 16'h0077, 16'h0010, 16);
    run_seg("sat1");
    mk_seg(16'hDDDE, 16'h0077, 16'h0010, 16);
    run_seg("sat2");

    // reset mid-forward: no abort pulse
    rst_after = 1;
    mk_seg(16'hEEEE, 16'h0050, 16'h0014, 10);
    run_seg("rst_mid");

    // randomized segments
    cfg_write(0, 1'b1, 16'h0050);
    cfg_write(1, 1'b1, 16'h1234);
    cfg_write(2, 1'b1, 16'h0050);
    cfg_write(3, 1'b1, 16'h0099);
    dsts[0] = 16'h0050; dsts[1] = 16'h1234; dsts[2] = 16'h0099;
    dsts[3] = 16'h0077; dsts[4] = 16'($urandom);
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 5) == 0)
        cfg_write(int'($urandom_range(0, 3)), 1'($urandom), dsts[$urandom_range(0, 3)]);
      l_r  = 16'($urandom_range(0, 24));
      full = (l_r > 16'd8) ? int'(l_r) : 8;
      if ($urandom_range(0, 3) == 0) n_r = int'($urandom_range(1, full - 1));
      else                           n_r = full + int'($urandom_range(0, 4));
      mk_seg(16'($urandom), dsts[$urandom_range(0, 4)], l_r, n_r);
      run_seg("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
